// File: rtl/uart_rx_deframer_if.sv
// Frame-in / entry-out bundle for uart_rx_deframer.
// Error counters appear only when UART_RX_DEFRAMER_ERR_CNT_EN is defined.
interface uart_rx_deframer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [10:0]   frame;
  logic          frame_active;
  logic          frame_done;
  logic          rd_ready;
  logic          clr_overrun;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_parity_err;
  logic          rd_frame_err;
  logic [CW-1:0] fifo_count;
  logic          overrun;
`ifdef UART_RX_DEFRAMER_ERR_CNT_EN
  logic [15:0]   parity_err_cnt;
  logic [15:0]   frame_err_cnt;
`endif

  modport slave (
    input  frame, frame_active, frame_done, rd_ready, clr_overrun,
    output rd_valid, rd_data, rd_parity_err, rd_frame_err, fifo_count, overrun
`ifdef UART_RX_DEFRAMER_ERR_CNT_EN
    , output parity_err_cnt, frame_err_cnt
`endif
  );

  modport master (
    output frame, frame_active, frame_done, rd_ready, clr_overrun,
    input  rd_valid, rd_data, rd_parity_err, rd_frame_err, fifo_count, overrun
`ifdef UART_RX_DEFRAMER_ERR_CNT_EN
    , input parity_err_cnt, frame_err_cnt
`endif
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// Captures completed 11-bit UART frames, checks start/stop/parity, queues entries in a FIFO.
// Optional saturating error counters: define UART_RX_DEFRAMER_ERR_CNT_EN.
module uart_rx_deframer #(
  parameter int DEPTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic               baud_clk,
  input  logic               reset,
  uart_rx_deframer_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic PAR_EXP = (PARITY_ODD != 0);

  logic          r_active_d;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;
  logic [9:0]    r_mem [DEPTH];

  logic          w_push_evt;
  logic          w_frame_err;
  logic          w_parity_err;
  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [9:0]    w_entry;
  logic [9:0]    w_head;

  // Falling edge of frame_active qualified by done: one push per frame even if done stays high.
  assign w_push_evt   = r_active_d & ~bus.frame_active & bus.frame_done;
  assign w_frame_err  = bus.frame[0] | ~bus.frame[10];
  assign w_parity_err = (^bus.frame[9:1]) != PAR_EXP;
  assign w_entry      = {w_frame_err, w_parity_err, bus.frame[8:1]};

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = w_valid & bus.rd_ready;
  assign w_push  = w_push_evt & (~w_full | w_pop);
  assign w_drop  = w_push_evt & w_full & ~w_pop;

  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      r_active_d <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_active_d <= bus.frame_active;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)               r_overrun <= 1'b1;
      else if (bus.clr_overrun) r_overrun <= 1'b0;
    end
  end

  // Storage needs no reset; outputs are gated by the count instead.
  always_ff @(posedge baud_clk) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  assign w_head            = r_mem[r_rptr];
  assign bus.rd_valid      = w_valid;
  assign bus.rd_data       = w_valid ? w_head[7:0] : 8'h00;
  assign bus.rd_parity_err = w_valid & w_head[8];
  assign bus.rd_frame_err  = w_valid & w_head[9];
  assign bus.fifo_count    = r_count;
  assign bus.overrun       = r_overrun;

`ifdef UART_RX_DEFRAMER_ERR_CNT_EN
  logic [15:0] r_par_cnt;
  logic [15:0] r_frm_cnt;

  // Counts every frame event, including frames dropped on overrun.
  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      r_par_cnt <= '0;
      r_frm_cnt <= '0;
    end else if (bus.clr_overrun) begin
      r_par_cnt <= '0;
      r_frm_cnt <= '0;
    end else begin
      if (w_push_evt & w_parity_err & (r_par_cnt != 16'hFFFF)) r_par_cnt <= r_par_cnt + 16'd1;
      if (w_push_evt & w_frame_err  & (r_frm_cnt != 16'hFFFF)) r_frm_cnt <= r_frm_cnt + 16'd1;
    end
  end

  assign bus.parity_err_cnt = r_par_cnt;
  assign bus.frame_err_cnt  = r_frm_cnt;
`endif
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer (DEPTH=4, even parity): vector table plus corner sequences.
module tb_uart_rx_deframer;
  logic baud_clk = 1'b0;
  logic reset    = 1'b0;
  always #5 baud_clk = ~baud_clk;

  uart_rx_deframer_if #(.DEPTH(4)) bus();
  uart_rx_deframer #(.DEPTH(4), .PARITY_ODD(0)) dut (
    .baud_clk (baud_clk),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    logic [10:0] frame;
    logic [7:0]  exp_data;
    logic        exp_perr;
    logic        exp_ferr;
  } vec_t;

  vec_t tbl [5];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge baud_clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic stop, input logic par, input logic [7:0] d,
                                     input logic start);
    return {stop, par, d, start};
  endfunction

  // Good frame with even parity for data d.
  function automatic logic [10:0] good(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  task automatic send(input logic [10:0] f, input logic rdy);
    bus.frame        = f;
    bus.frame_active = 1'b1;
    bus.frame_done   = 1'b0;
    tick();
    bus.frame_active = 1'b0;
    bus.frame_done   = 1'b1;
    bus.rd_ready     = rdy;
    tick();
    bus.frame_done   = 1'b0;
    bus.rd_ready     = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk({nm, "_valid"}, bus.rd_valid, 1);
    chk(nm, bus.rd_data, exp);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    bus.frame = '0; bus.frame_active = 1'b0; bus.frame_done = 1'b0;
    bus.rd_ready = 1'b0; bus.clr_overrun = 1'b0;

    tbl[0] = '{11'b1_0_01010101_0,  8'h55, 1'b0, 1'b0};
    tbl[1] = '{mk(1, 0, 8'h01, 0),  8'h01, 1'b1, 1'b0};
    tbl[2] = '{mk(0, 0, 8'h55, 0),  8'h55, 1'b0, 1'b1};
    tbl[3] = '{mk(1, 1, 8'h03, 1),  8'h03, 1'b1, 1'b1};
    tbl[4] = '{mk(1, 1, 8'h80, 0),  8'h80, 1'b0, 1'b0};

    #3;
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_data",  bus.rd_data, 0);
    chk("rst_perr",  bus.rd_parity_err, 0);
    chk("rst_ferr",  bus.rd_frame_err, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_ovr",   bus.overrun, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].frame, 1'b0);
      chk($sformatf("v%0d_valid", i), bus.rd_valid, 1);
      chk($sformatf("v%0d_data",  i), bus.rd_data, tbl[i].exp_data);
      chk($sformatf("v%0d_perr",  i), bus.rd_parity_err, tbl[i].exp_perr);
      chk($sformatf("v%0d_ferr",  i), bus.rd_frame_err, tbl[i].exp_ferr);
      chk($sformatf("v%0d_cnt1",  i), bus.fifo_count, 1);
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
      chk($sformatf("v%0d_cnt0",  i), bus.fifo_count, 0);
      chk($sformatf("v%0d_empty", i), bus.rd_valid, 0);
    end

`ifdef UART_RX_DEFRAMER_ERR_CNT_EN
    chk("perr_cnt", bus.parity_err_cnt, 2);
    chk("ferr_cnt", bus.frame_err_cnt, 2);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    chk("perr_cnt_clr", bus.parity_err_cnt, 0);
    chk("ferr_cnt_clr", bus.frame_err_cnt, 0);
`endif

    // Latency, and push into empty FIFO while rd_ready is high.
    bus.frame = good(8'h55);
    bus.frame_active = 1'b1;
    tick();
    bus.frame_active = 1'b0;
    bus.frame_done = 1'b1;
    bus.rd_ready = 1'b1;
    chk("lat_pre_valid", bus.rd_valid, 0);
    tick();
    bus.frame_done = 1'b0;
    bus.rd_ready = 1'b0;
    chk("lat_valid", bus.rd_valid, 1);
    chk("lat_cnt",   bus.fifo_count, 1);
    tick(); tick();
    chk("hold_data", bus.rd_data, 8'h55);
    pop_chk("lat_pop", 8'h55);
    chk("lat_cnt0", bus.fifo_count, 0);

    // Overflow: five frames into four slots.
    for (int k = 0; k < 5; k++) send(good(8'h10 + 8'(k)), 1'b0);
    chk("ovf_cnt", bus.fifo_count, 4);
    chk("ovf_ovr", bus.overrun, 1);
    bus.frame = good(8'h15);
    bus.frame_active = 1'b1;
    tick();
    bus.frame_active = 1'b0;
    bus.frame_done = 1'b1;
    bus.clr_overrun = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    bus.clr_overrun = 1'b0;
    chk("ovf_set_wins", bus.overrun, 1);
    chk("ovf_cnt_hold", bus.fifo_count, 4);
    pop_chk("ovf_p0", 8'h10);
    pop_chk("ovf_p1", 8'h11);
    pop_chk("ovf_p2", 8'h12);
    pop_chk("ovf_p3", 8'h13);
    chk("ovf_cnt0", bus.fifo_count, 0);
    chk("ovf_sticky", bus.overrun, 1);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    chk("ovf_clr", bus.overrun, 0);

    // Full with simultaneous push and pop.
    for (int k = 0; k < 4; k++) send(good(8'h20 + 8'(k)), 1'b0);
    chk("fpp_cnt_pre", bus.fifo_count, 4);
    send(good(8'h24), 1'b1);
    chk("fpp_cnt", bus.fifo_count, 4);
    chk("fpp_ovr", bus.overrun, 0);
    pop_chk("fpp_p0", 8'h21);
    pop_chk("fpp_p1", 8'h22);
    pop_chk("fpp_p2", 8'h23);
    pop_chk("fpp_p3", 8'h24);
    chk("fpp_cnt0", bus.fifo_count, 0);

    // frame_done held high across three frames.
    bus.frame_done = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.frame = good(8'h30 + 8'(k));
      bus.frame_active = 1'b1;
      tick(); tick();
      bus.frame_active = 1'b0;
      tick(); tick();
    end
    bus.frame_done = 1'b0;
    chk("held_cnt", bus.fifo_count, 3);
    pop_chk("held_p0", 8'h30);
    pop_chk("held_p1", 8'h31);
    pop_chk("held_p2", 8'h32);

    // frame_done pulse without frame_active.
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    tick();
    chk("pulse_cnt",   bus.fifo_count, 0);
    chk("pulse_valid", bus.rd_valid, 0);

    // Asynchronous reset mid-operation.
    for (int k = 0; k < 5; k++) send(good(8'h40 + 8'(k)), 1'b0);
    chk("mid_ovr_pre", bus.overrun, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_valid", bus.rd_valid, 0);
    chk("mid_cnt",   bus.fifo_count, 0);
    chk("mid_ovr",   bus.overrun, 0);
    chk("mid_data",  bus.rd_data, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_cnt_after", bus.fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side stage directly downstream of the serial-to-parallel shifter.
- Captures each completed 11-bit frame, checks start, stop and parity bits, and extracts the 8-bit payload.
- Buffers payload plus error status in a small FIFO.
- Presents entries to the host side through a valid/ready handshake.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
baud_clk  input  1  sole clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
frame  input  11  received frame; bit0 start, bits1..8 data LSB first, bit9 parity, bit10 stop.
frame_active  input  1  high while the shifter is collecting a frame.
frame_done  input  1  shifter done indication; level, not guaranteed to self-clear.
rd_ready  input  1  consumer accepts the head entry this cycle.
clr_overrun  input  1  synchronous clear of the overrun flag.
rd_valid  output  1  head entry available.
rd_data  output  8  head entry payload.
rd_parity_err  output  1  head entry failed the parity check.
rd_frame_err  output  1  head entry had start!=0 or stop!=1.
fifo_count  output  $clog2(DEPTH)+1  number of stored entries.
overrun  output  1  sticky; a frame was dropped because the FIFO was full.

Behaviour:
- Reset (reset==0, asynchronous):
  - rd_valid=0, rd_data=0, rd_parity_err=0, rd_frame_err=0, fifo_count=0, overrun=0.
  - Pointers=0, active_d=0.
  - Any in-flight capture is discarded; FIFO contents become don't-care.
- Frame event:
  - Register active_d <= frame_active every cycle.
  - push_evt = active_d & ~frame_active & frame_done, i.e. falling edge of frame_active while frame_done is high.
  - frame is sampled in the same cycle push_evt is true; exactly one push per frame regardless of how long frame_done stays high.
  - frame_done high without an active falling edge: no push.
- Checks, combinational on the sampled frame:
  - frame_err = frame[0] | ~frame[10].
  - parity_err = (^frame[9:1]) != PARITY_ODD.
  - Payload = frame[8:1], frame[1] = bit0.
- Entries: 10 bits each {frame_err, parity_err, data}. Frames with errors are still stored; the consumer decides.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - Pop = rd_valid & rd_ready. Push = push_evt & (not full | pop).
  - Full and push_evt without pop: frame dropped, overrun<=1, contents unchanged.
  - Full with simultaneous push and pop: both occur, fifo_count unchanged, no overrun.
  - Empty with push_evt and rd_ready: push only; rd_valid is 0 that cycle.
  - fifo_count += push - pop.
- Outputs:
  - rd_valid = (fifo_count != 0).
  - rd_data / rd_parity_err / rd_frame_err show the head entry, driven from registered storage.
  - Latency: push_evt sampled at edge N, so rd_valid=1 after edge N (visible in cycle N+1) when previously empty.
  - Head data holds stable while rd_valid=1 and rd_ready=0.
- Overrun:
  - Set on a drop; cleared by clr_overrun.
  - Drop and clr_overrun in the same cycle: set wins.
- Width rule: fifo_count never exceeds DEPTH; never underflows (pop requires rd_valid).

Optional Feature:
- Macro: UART_RX_DEFRAMER_ERR_CNT_EN.
- Defined:
  - Adds outputs parity_err_cnt[15:0] and frame_err_cnt[15:0].
  - Each increments by 1 on every push_evt whose frame has the respective error, including dropped frames.
  - Counters saturate at 16'hFFFF, reset to 0 on reset, and are also cleared by clr_overrun.
- Not defined: ports and counter logic absent; all other behaviour identical.

Test Plan:
- Reset mid-operation: push 2 frames, assert reset=0 for 1 cycle → rd_valid=0, fifo_count=0, overrun=0 immediately, before the next clock edge.
- Good frame 11'b1_0_01010101_0 (data 8'h55, parity 0, PARITY_ODD=0) → rd_valid=1 one cycle after push_evt, rd_data=8'h55, both error bits 0; rd_ready=1 pops, fifo_count back to 0.
- Parity error: data 8'h01 with parity bit 0 → rd_parity_err=1; frame with stop bit 0 → rd_frame_err=1; with the macro defined, parity_err_cnt=1 and frame_err_cnt=1.
- Overflow, DEPTH=4, rd_ready=0: push 5 frames (8'h10..8'h14) → fifo_count=4, overrun=1, pops return 10,11,12,13; clr_overrun → overrun=0.
- Full with simultaneous push and pop: 4 entries held, push_evt with rd_ready=1 → fifo_count stays 4, overrun stays 0, order preserved.
- frame_done held high across 3 frames → exactly 3 entries; a frame_done pulse with frame_active low throughout → no entry.
